// File: rtl/sha_const.sv
// Shared SHA-256 constants, round helper functions and controller state type.
// Nl is the default message length in bytes; Nk is the digest width in bits.
package sha_const;

    localparam int Nl = 3;
    localparam int Nk = 256;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] H_INIT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    function automatic logic [31:0] Ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] Maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] BigSigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] BigSigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] SmallSigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] SmallSigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: working registers A..H
// (index 0..7) plus the round constant and schedule word give the next A..H.
module sha256_round
    import sha_const::*;
(
    input  logic [31:0] i_work [0:7],
    input  logic [31:0] i_k,
    input  logic [31:0] i_w,
    output logic [31:0] o_work [0:7]
);

    logic [31:0] w_t1;
    logic [31:0] w_t2;

    always_comb begin
        w_t1 = i_work[7] + BigSigma1(i_work[4]) + Ch(i_work[4], i_work[5], i_work[6]) + i_k + i_w;
        w_t2 = BigSigma0(i_work[0]) + Maj(i_work[0], i_work[1], i_work[2]);
        o_work[0] = w_t1 + w_t2;
        o_work[1] = i_work[0];
        o_work[2] = i_work[1];
        o_work[3] = i_work[2];
        o_work[4] = i_work[3] + w_t1;
        o_work[5] = i_work[4];
        o_work[6] = i_work[5];
        o_work[7] = i_work[6];
    end

endmodule

// File: rtl/sha256_core.sv
// Single-block SHA-256 engine: pads an Nl-byte message, runs 64 rounds one per
// clock over a sliding 16-word schedule window, then pulses Ready with the digest.
module sha256_core #(
    parameter int Nl = sha_const::Nl
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               Data [0:Nl-1],
    input  logic                     Enable,
    output logic [sha_const::Nk-1:0] Hash,
    output logic                     Ready
);
    import sha_const::state_t, sha_const::IDLE, sha_const::ROUND, sha_const::DONE;
    import sha_const::K, sha_const::H_INIT, sha_const::SmallSigma0, sha_const::SmallSigma1;

    state_t       r_state;
    state_t       w_nextState;
    logic [5:0]   r_cnt;
    logic [31:0]  r_work [0:7];
    logic [31:0]  r_w [0:15];
    logic [31:0]  w_roundOut [0:7];
    logic [31:0]  w_wNext;
    logic [511:0] w_block;
    logic [255:0] r_hash;
    logic         r_ready;

    // Padded block: message, 0x80 marker, zero fill, 64-bit big-endian bit length.
    always_comb begin
        w_block = '0;
        for (int i = 0; i < Nl; i++) begin
            w_block[511 - 8*i -: 8] = Data[i];
        end
        w_block[511 - 8*Nl -: 8] = 8'h80;
        w_block[63:0] = 64'(Nl * 8);
    end

    assign w_wNext = SmallSigma1(r_w[14]) + r_w[9] + SmallSigma0(r_w[1]) + r_w[0];

    sha256_round u_round (
        .i_work (r_work),
        .i_k    (K[r_cnt]),
        .i_w    (r_w[0]),
        .o_work (w_roundOut)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (Enable) w_nextState = ROUND;
            ROUND:   if (r_cnt == 6'd63) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // H0..H7 are always the initial values for a single block, so the final add uses H_INIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_hash  <= '0;
            r_ready <= 1'b0;
            for (int j = 0; j < 8; j++) r_work[j] <= '0;
            for (int j = 0; j < 16; j++) r_w[j] <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Enable) begin
                        r_cnt <= '0;
                        for (int j = 0; j < 16; j++) r_w[j] <= w_block[511 - 32*j -: 32];
                        for (int j = 0; j < 8; j++) r_work[j] <= H_INIT[j];
                    end
                end
                ROUND: begin
                    r_cnt <= r_cnt + 6'd1;
                    for (int j = 0; j < 8; j++) r_work[j] <= w_roundOut[j];
                    for (int j = 0; j < 15; j++) r_w[j] <= r_w[j+1];
                    r_w[15] <= w_wNext;
                end
                DONE: begin
                    r_ready <= 1'b1;
                    for (int j = 0; j < 8; j++) r_hash[255 - 32*j -: 32] <= H_INIT[j] + r_work[j];
                end
                default: ;
            endcase
        end
    end

    assign Hash  = r_hash;
    assign Ready = r_ready;

endmodule

// File: doc/sha256_core.md
Name: sha256_core

Overview:
- Single-block SHA-256 responder: accepts an Nl-byte message on a one-cycle Enable strobe and returns the 256-bit digest with a one-cycle Ready pulse.
- It is the engine behind the Data/Enable → Hash/Ready interface that the sha test bench drives.
- Pads internally and runs one compression round per clock.

Parameters:
- Nl, 3 (from sha_const), message length in bytes; legal range 1..55, so the message always fits one padded 512-bit block.
- Nk, 256 (from sha_const), digest width in bits; fixed.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- Data  in  8 x Nl (unpacked array [0:Nl-1])  message bytes; Data[0] is the first byte.
- Enable  in  1  start strobe; sampled on rising clk.
- Hash  out  Nk  digest; H0 in bits [255:224] through H7 in bits [31:0].
- Ready  out  1  one-cycle pulse when Hash is valid.

Behaviour:
- Reset (rst=0, async), all outputs and internal state:
  - Ready=0, Hash=0, state=IDLE, round counter=0, working regs A..H=0, schedule window W[0:15]=0.
- States: IDLE, ROUND, DONE.
- IDLE:
  - On Enable=1, build the padded block:
    - bytes 0..Nl-1 = Data
    - byte Nl = 0x80
    - bytes Nl+1..55 = 0x00
    - bytes 56..63 = Nl*8 as a 64-bit big-endian value
  - Load W[0:15] as big-endian 32-bit words.
  - Load A..H and H0..H7 with the FIPS 180-4 initial values; counter=0; go to ROUND.
  - Data is captured only on this edge; later changes to Data are ignored.
- ROUND (64 cycles, t=0..63):
  - Compute T1 = H + Σ1(E) + Ch(E,F,G) + K[t] + W[0] and T2 = Σ0(A) + Maj(A,B,C).
  - Update A..H per the standard round.
  - Shift W left by one and append σ1(W[14]) + W[9] + σ0(W[1]) + W[0].
  - All additions are mod 2^32; carries are discarded.
  - At t=63, go to DONE.
- DONE (1 cycle):
  - Hash <= {H0+A, …, H7+H}, each word mod 2^32.
  - Ready <= 1; state <= IDLE.
- Ready is a registered pulse, high for exactly one cycle.
- Hash holds its value until the next DONE or reset.
- Latency: Enable sampled at edge k → ROUND on edges k+1..k+64 → Hash/Ready updated at edge k+65, so Ready is high during cycle k+65 to k+66.
- Enable while in ROUND or DONE is ignored; no queueing and no error flag.
- Enable held high across many cycles:
  - It starts one operation.
  - A still-high Enable in the cycle Ready is high (the IDLE cycle) starts the next operation.
  - Back-to-back throughput is therefore one digest per 66 cycles.
- Reset asserted mid-ROUND aborts the operation:
  - No Ready is produced.
  - Hash clears to 0.
  - After release, the next Enable behaves normally.
- K[0:63] is a constant ROM and is not reset.

Decomposition:
- Extend the sha_const package with:
  - Nl, Nk
  - K table (64 x 32-bit)
  - H_INIT (8 x 32-bit)
  - a state enum typedef (IDLE/ROUND/DONE)
  - functions Ch, Maj, Σ0, Σ1, σ0, σ1
- Sub-module sha256_round (combinational):
  - inputs: A..H, K[t], W[0]
  - outputs: next A..H
- sha256_core holds the FSM, counter, schedule window and final addition.

Test Plan:
- Nl=3, Data="abc" (61 62 63), 1-cycle Enable → Ready at edge k+65; Hash = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; Ready low on the following cycle.
- Two "abc" requests back-to-back, second Enable in the Ready cycle → second Ready exactly 66 cycles after the first, with the same digest.
- Enable pulsed at round t=10 and again at t=63 → exactly one Ready, correct digest; Data changed after start does not affect the result.
- rst=0 asserted at round t=30, released 3 cycles later → Ready never pulses, Hash=0; a new "abc" request yields the correct digest.
- Nl=55 build, 55 random bytes (≥20 seeds) → Hash matches the reference model, covering the length field 0x1B8 and 0x80 at byte 55.
- Reset value check → immediately after async rst falls mid-cycle (no clock edge), Ready=0 and Hash=0.
